dcu_fill_buf: RTL and testbench

Data-cache line-fill buffer, directly upstream of the data cache RAM write port. On a miss it requests a 16-byte line from the bus interface, collects four 32-bit words in critical-word-first wrap order, and writes each word into the selected way of the cache RAM whenever the pipeline leaves the RAM port free. It also forwards the critical word to the load pipeline.

---
 rtl/dcu_fill_pkg.sv | 17 +
 rtl/fill_line_buf.sv | 28 ++
 rtl/dcu_fill_buf.sv | 141 ++++++++++++++
 tb/tb_dcu_fill_buf.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcu_fill_pkg.sv
// Shared types and constants for the data-cache line-fill buffer.
package dcu_fill_pkg;

  localparam int LINE_WORDS = 4;
  localparam int SLOT_W     = 2;
  localparam logic [3:0] WE_ALL = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    FILL,
    DONE
  } fill_state_e;

  typedef logic [SLOT_W-1:0] slot_t;

endpackage

// File: rtl/fill_line_buf.sv
// Four-word line holding buffer: one write port, two asynchronous read
// ports (RAM write-out and critical-word forwarding).
module fill_line_buf
  import dcu_fill_pkg::*;
(
  input  logic        clk,
  input  logic        wr_en,
  input  slot_t       wr_slot,
  input  logic [31:0] wr_data,
  input  slot_t       rd_slot,
  output logic [31:0] rd_data,
  input  slot_t       fwd_slot,
  output logic [31:0] fwd_data
);

  logic [31:0] mem [LINE_WORDS];

  // Store one received word into its wrap-order slot.
  // NOTE: the storage has no reset; a slot is always written before the
  // write-out or forward path is allowed to read it.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_slot] <= wr_data;
  end

  assign rd_data  = mem[rd_slot];
  assign fwd_data = mem[fwd_slot];

endmodule

// File: rtl/dcu_fill_buf.sv
// Data-cache line-fill buffer: requests a line from the bus interface,
// gathers four words critical-word-first and drains them into the cache
// RAM whenever the pipeline leaves the port free.
module dcu_fill_buf
  import dcu_fill_pkg::*;
#(
  parameter int AMSB       = 12,
  parameter int LINE_WORDS = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fill_req,
  input  logic [AMSB:0]   fill_addr,
  input  logic [1:0]      fill_way,
  output logic            fill_busy,
  output logic            fill_done,
  output logic            biu_req,
  output logic [AMSB:0]   biu_addr,
  input  logic            biu_ack,
  input  logic            biu_data_vld,
  input  logic [31:0]     biu_data,
  output logic            fwd_vld,
  output logic [31:0]     fwd_data,
  input  logic            ram_busy,
  output logic            dc_enable,
  output logic [3:0]      dc_we,
  output logic [1:0]      dc_bank_sel,
  output logic [AMSB:0]   dc_addr,
  output logic [63:0]     dc_data
);

  fill_state_e     state;
  logic [AMSB-4:0] line;
  slot_t           crit;
  logic [1:0]      way;
  logic [2:0]      rcv_cnt;
  logic [2:0]      wr_cnt;

  logic            accept;
  logic            wr_go;
  slot_t           rcv_slot;
  slot_t           wr_slot;
  logic [31:0]     wr_word;
  logic [31:0]     fwd_word;

  // A word is taken in FILL, or in REQ when it rides along with the ack,
  // until the whole line has arrived.
  assign accept = ((state == REQ && biu_ack) || state == FILL) && biu_data_vld &&
                  (rcv_cnt < 3'(LINE_WORDS));
  // Drain only words stored in earlier cycles; never write during reset.
  assign wr_go  = (state == FILL) && (wr_cnt < rcv_cnt) && !ram_busy && !reset;

  assign rcv_slot = crit + rcv_cnt[1:0];
  assign wr_slot  = crit + wr_cnt[1:0];

  fill_line_buf u_line_buf (
    .clk      (clk),
    .wr_en    (accept),
    .wr_slot  (rcv_slot),
    .wr_data  (biu_data),
    .rd_slot  (wr_slot),
    .rd_data  (wr_word),
    .fwd_slot (crit),
    .fwd_data (fwd_word)
  );

  // Fill sequencing FSM with counters and registered handshake outputs.
  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      line      <= '0;
      crit      <= '0;
      way       <= '0;
      rcv_cnt   <= '0;
      wr_cnt    <= '0;
      fwd_vld   <= 1'b0;
      biu_req   <= 1'b0;
      fill_busy <= 1'b0;
      fill_done <= 1'b0;
    end else begin
      fwd_vld <= accept && (rcv_cnt == 3'd0);
      if (accept) rcv_cnt <= rcv_cnt + 3'd1;
      if (wr_go)  wr_cnt  <= wr_cnt + 3'd1;
      case (state)
        IDLE: begin
          if (fill_req) begin
            line      <= fill_addr[AMSB:4];
            crit      <= fill_addr[3:2];
            way       <= fill_way;
            rcv_cnt   <= '0;
            wr_cnt    <= '0;
            biu_req   <= 1'b1;
            fill_busy <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          if (biu_ack) begin
            biu_req <= 1'b0;
            state   <= FILL;
          end
        end
        FILL: begin
          if (wr_go && wr_cnt == 3'(LINE_WORDS - 1)) begin
            fill_done <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          fill_done <= 1'b0;
          fill_busy <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign biu_addr = {line, crit, 2'b00};
  assign fwd_data = fwd_vld ? fwd_word : 32'h0;

  // RAM write port drive; idle values are zero so reset shows all-zero outputs.
  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    dc_enable   = 1'b0;
    dc_we       = 4'h0;
    dc_bank_sel = 2'b00;
    dc_addr     = '0;
    dc_data     = '0;
    if (wr_go) begin
      dc_enable   = 1'b1;
      dc_we       = WE_ALL;
      dc_bank_sel = way;
      dc_addr     = {line, wr_slot, 2'b00};
      dc_data     = {wr_word, wr_word};
    end
  end

endmodule

// File: tb/tb_dcu_fill_buf.sv
// Directed self-checking bench for dcu_fill_buf.
module tb_dcu_fill_buf;

  logic        clk;
  logic        reset;
  logic        fill_req;
  logic [12:0] fill_addr;
  logic [1:0]  fill_way;
  logic        fill_busy;
  logic        fill_done;
  logic        biu_req;
  logic [12:0] biu_addr;
  logic        biu_ack;
  logic        biu_data_vld;
  logic [31:0] biu_data;
  logic        fwd_vld;
  logic [31:0] fwd_data;
  logic        ram_busy;
  logic        dc_enable;
  logic [3:0]  dc_we;
  logic [1:0]  dc_bank_sel;
  logic [12:0] dc_addr;
  logic [63:0] dc_data;

  int checks   = 0;
  int failures = 0;

  dcu_fill_buf #(.AMSB(12), .LINE_WORDS(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .fill_req     (fill_req),
    .fill_addr    (fill_addr),
    .fill_way     (fill_way),
    .fill_busy    (fill_busy),
    .fill_done    (fill_done),
    .biu_req      (biu_req),
    .biu_addr     (biu_addr),
    .biu_ack      (biu_ack),
    .biu_data_vld (biu_data_vld),
    .biu_data     (biu_data),
    .fwd_vld      (fwd_vld),
    .fwd_data     (fwd_data),
    .ram_busy     (ram_busy),
    .dc_enable    (dc_enable),
    .dc_we        (dc_we),
    .dc_bank_sel  (dc_bank_sel),
    .dc_addr      (dc_addr),
    .dc_data      (dc_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after inputs change.
  task automatic settle();
    #1;
  endtask

  task automatic expect_wr(input string tag, input logic [12:0] addr,
                           input logic [31:0] word, input logic [1:0] way);
    check({tag, ".en"},   dc_enable, 1);
    check({tag, ".we"},   dc_we, 4'hF);
    check({tag, ".way"},  dc_bank_sel, way);
    check({tag, ".addr"}, dc_addr, addr);
    check({tag, ".data"}, dc_data, {word, word});
  endtask

  task automatic expect_no_wr(input string tag);
    check({tag, ".en"},  dc_enable, 0);
    check({tag, ".we"},  dc_we, 0);
    check({tag, ".way"}, dc_bank_sel, 0);
  endtask

  task automatic expect_all_zero(input string tag);
    check({tag, ".busy"},     fill_busy, 0);
    check({tag, ".done"},     fill_done, 0);
    check({tag, ".biu_req"},  biu_req, 0);
    check({tag, ".biu_addr"}, biu_addr, 0);
    check({tag, ".fwd_vld"},  fwd_vld, 0);
    check({tag, ".fwd_data"}, fwd_data, 0);
    check({tag, ".dc_addr"},  dc_addr, 0);
    check({tag, ".dc_data"},  dc_data, 0);
    expect_no_wr(tag);
  endtask

  initial begin
    reset        = 1'b1;
    fill_req     = 1'b0;
    fill_addr    = '0;
    fill_way     = '0;
    biu_ack      = 1'b0;
    biu_data_vld = 1'b0;
    biu_data     = '0;
    ram_busy     = 1'b0;
    tick();
    tick();
    settle();
    expect_all_zero("reset");

    // ---- Basic fill: 0x1A4, crit=1, way 01 ----
    reset     = 1'b0;
    fill_req  = 1'b1;
    fill_addr = 13'h1A4;
    fill_way  = 2'b01;
    tick();
    fill_req = 1'b0;
    biu_ack  = 1'b1;
    settle();
    check("b.req", biu_req, 1);
    check("b.busy", fill_busy, 1);
    check("b.biu_addr", biu_addr, 13'h1A4);
    expect_no_wr("b.req_nowr");
    tick();
    biu_ack = 1'b0; biu_data_vld = 1'b1; biu_data = 32'hA0;
    settle();
    check("b.req_drop", biu_req, 0);
    expect_no_wr("b.nobypass");
    tick();
    biu_data = 32'hA1;
    settle();
    check("b.fwd_vld", fwd_vld, 1);
    check("b.fwd_data", fwd_data, 32'hA0);
    expect_wr("b.w0", 13'h1A4, 32'hA0, 2'b01);
    tick();
    biu_data = 32'hA2;
    settle();
    check("b.fwd_once", fwd_vld, 0);
    expect_wr("b.w1", 13'h1A8, 32'hA1, 2'b01);
    tick();
    biu_data = 32'hA3;
    settle();
    expect_wr("b.w2", 13'h1AC, 32'hA2, 2'b01);
    tick();
    biu_data_vld = 1'b0;
    settle();
    expect_wr("b.w3", 13'h1A0, 32'hA3, 2'b01);
    check("b.done_early", fill_done, 0);
    tick();
    settle();
    check("b.done", fill_done, 1);
    check("b.busy_done", fill_busy, 1);
    expect_no_wr("b.done_nowr");
    tick();
    settle();
    check("b.done_pulse", fill_done, 0);
    check("b.idle", fill_busy, 0);

    // ---- ram_busy held 6 cycles: 0x040, crit=0, way 10 ----
    fill_req  = 1'b1;
    fill_addr = 13'h040;
    fill_way  = 2'b10;
    tick();
    fill_req = 1'b0; biu_ack = 1'b1;
    tick();
    biu_ack = 1'b0; biu_data_vld = 1'b1; biu_data = 32'hB0; ram_busy = 1'b1;
    settle();
    expect_no_wr("rb.c0");
    tick();
    biu_data = 32'hB1;
    settle();
    check("rb.fwd_data", fwd_data, 32'hB0);
    expect_no_wr("rb.c1");
    tick();
    biu_data = 32'hB2;
    settle();
    expect_no_wr("rb.c2");
    tick();
    biu_data = 32'hB3;
    settle();
    expect_no_wr("rb.c3");
    tick();
    biu_data_vld = 1'b0;
    settle();
    expect_no_wr("rb.c4");
    tick();
    settle();
    expect_no_wr("rb.c5");
    check("rb.busy", fill_busy, 1);
    check("rb.no_done", fill_done, 0);
    tick();
    ram_busy = 1'b0;
    settle();
    expect_wr("rb.w0", 13'h040, 32'hB0, 2'b10);
    tick();
    settle();
    expect_wr("rb.w1", 13'h044, 32'hB1, 2'b10);
    tick();
    settle();
    expect_wr("rb.w2", 13'h048, 32'hB2, 2'b10);
    tick();
    settle();
    expect_wr("rb.w3", 13'h04C, 32'hB3, 2'b10);
    tick();
    settle();
    check("rb.done", fill_done, 1);
    tick();

    // ---- ack+data together, extra word, req while busy: 0x10C, crit=3 ----
    fill_req  = 1'b1;
    fill_addr = 13'h10C;
    fill_way  = 2'b10;
    tick();
    fill_addr = 13'h0F0;
    fill_way  = 2'b01;
    biu_ack = 1'b1; biu_data_vld = 1'b1; biu_data = 32'hC0;
    settle();
    check("ad.biu_addr", biu_addr, 13'h10C);
    tick();
    biu_ack = 1'b0; biu_data = 32'hC1;
    settle();
    check("ad.fwd_vld", fwd_vld, 1);
    check("ad.fwd_data", fwd_data, 32'hC0);
    check("ad.ignored_req", biu_addr, 13'h10C);
    expect_wr("ad.w0", 13'h10C, 32'hC0, 2'b10);
    tick();
    biu_data = 32'hC2;
    settle();
    expect_wr("ad.w1", 13'h100, 32'hC1, 2'b10);
    tick();
    biu_data = 32'hC3;
    settle();
    expect_wr("ad.w2", 13'h104, 32'hC2, 2'b10);
    tick();
    biu_data = 32'hC4;
    settle();
    expect_wr("ad.w3", 13'h108, 32'hC3, 2'b10);
    tick();
    biu_data_vld = 1'b0;
    settle();
    check("ad.done", fill_done, 1);
    expect_no_wr("ad.no_fifth");
    tick();
    settle();
    check("ad.idle", fill_busy, 0);
    check("ad.idle_req", biu_req, 0);
    expect_no_wr("ad.idle_nowr");
    tick();
    fill_req = 1'b0; biu_ack = 1'b1;
    settle();
    check("nf.req", biu_req, 1);
    check("nf.biu_addr", biu_addr, 13'h0F0);
    tick();

    // ---- reset after two words received, one written ----
    biu_ack = 1'b0; biu_data_vld = 1'b1; biu_data = 32'hD0;
    settle();
    expect_no_wr("rs.c0");
    tick();
    biu_data = 32'hD1;
    settle();
    expect_wr("rs.w0", 13'h0F0, 32'hD0, 2'b01);
    tick();
    biu_data_vld = 1'b0; reset = 1'b1;
    settle();
    expect_no_wr("rs.during");
    tick();
    reset = 1'b0;
    settle();
    expect_all_zero("rs.after");
    tick();
    settle();
    expect_no_wr("rs.after2");
    check("rs.idle", fill_busy, 0);

    // ---- normal fill after reset: 0x2B8, crit=2, way 10 ----
    fill_req  = 1'b1;
    fill_addr = 13'h2B8;
    fill_way  = 2'b10;
    tick();
    fill_req = 1'b0; biu_ack = 1'b1;
    settle();
    check("pr.biu_addr", biu_addr, 13'h2B8);
    tick();
    biu_ack = 1'b0; biu_data_vld = 1'b1; biu_data = 32'hE0;
    tick();
    biu_data = 32'hE1;
    settle();
    check("pr.fwd_data", fwd_data, 32'hE0);
    expect_wr("pr.w0", 13'h2B8, 32'hE0, 2'b10);
    tick();
    biu_data = 32'hE2;
    settle();
    expect_wr("pr.w1", 13'h2BC, 32'hE1, 2'b10);
    tick();
    biu_data = 32'hE3;
    settle();
    expect_wr("pr.w2", 13'h2B0, 32'hE2, 2'b10);
    tick();
    biu_data_vld = 1'b0;
    settle();
    expect_wr("pr.w3", 13'h2B4, 32'hE3, 2'b10);
    tick();
    settle();
    check("pr.done", fill_done, 1);
    tick();
    settle();
    check("pr.idle", fill_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
